pio_count_sequencer: RTL and testbench

PIO_COUNT_SEQUENCER -- requirements
Module: pio_count_sequencer

---
 rtl/pio_count_sequencer.sv | 121 ++++++++++++
 tb/tb_pio_count_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_count_sequencer.sv
// Avalon-MM slave that drives an 8-bit PIO with a prescaled up/down counter.
// Supports a programmable limit, a oneshot mode and a sticky done flag with a level interrupt.
module pio_count_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        irq
);

  logic [7:0]  count_reg, count_next;
  logic        run_reg, run_next;
  logic        dir_reg, oneshot_reg, irq_en_reg;
  logic [15:0] prescale_reg;
  logic [15:0] psc_reg, psc_next;
  logic [7:0]  limit_reg;
  logic        done_reg, done_next;

  logic wr_en, wr_count, wr_ctrl, wr_presc, wr_limit;
  logic tick, terminal, start;
  logic unused_wdata;

  assign wr_en    = chipselect & ~write_n;
  assign wr_count = wr_en & (address == 2'd0);
  assign wr_ctrl  = wr_en & (address == 2'd1);
  assign wr_presc = wr_en & (address == 2'd2);
  assign wr_limit = wr_en & (address == 2'd3);

  assign tick     = run_reg & (psc_reg == 16'd0);
  assign terminal = dir_reg ? (count_reg == 8'd0) : (count_reg == limit_reg);
  // Only a 0->1 transition of run restarts the prescaler phase.
  assign start    = wr_ctrl & writedata[0] & ~run_reg;

  assign unused_wdata = ^writedata[31:16];

  always_comb begin
    psc_next = psc_reg;
    if (start || tick) begin
      psc_next = prescale_reg;
    end else if (run_reg) begin
      psc_next = psc_reg - 16'd1;
    end
  end

  // Clear is applied before the tick so a simultaneous done-set wins;
  // a COUNT write suppresses all count-side effects of the tick.
  always_comb begin
    count_next = count_reg;
    done_next  = done_reg;
    run_next   = run_reg;
    if (wr_limit && writedata[8]) begin
      done_next = 1'b0;
    end
    if (tick && !wr_count) begin
      if (terminal) begin
        done_next = 1'b1;
        if (oneshot_reg) begin
          run_next = 1'b0;
        end else begin
          count_next = dir_reg ? limit_reg : 8'd0;
        end
      end else begin
        count_next = dir_reg ? (count_reg - 8'd1) : (count_reg + 8'd1);
      end
    end
    if (wr_count) begin
      count_next = writedata[7:0];
    end
    if (wr_ctrl) begin
      run_next = writedata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg    <= 8'd0;
      run_reg      <= 1'b0;
      dir_reg      <= 1'b0;
      oneshot_reg  <= 1'b0;
      irq_en_reg   <= 1'b0;
      prescale_reg <= 16'd0;
      psc_reg      <= 16'd0;
      limit_reg    <= 8'hFF;
      done_reg     <= 1'b0;
    end else begin
      count_reg <= count_next;
      run_reg   <= run_next;
      done_reg  <= done_next;
      psc_reg   <= psc_next;
      if (wr_ctrl) begin
        dir_reg     <= writedata[1];
        oneshot_reg <= writedata[2];
        irq_en_reg  <= writedata[3];
      end
      if (wr_presc) begin
        prescale_reg <= writedata[15:0];
      end
      if (wr_limit) begin
        limit_reg <= writedata[7:0];
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {24'd0, count_reg};
      2'd1:    readdata = {28'd0, irq_en_reg, oneshot_reg, dir_reg, run_reg};
      2'd2:    readdata = {16'd0, prescale_reg};
      default: readdata = {23'd0, done_reg, limit_reg};
    endcase
  end

  assign out_port = count_reg;
  assign irq      = done_reg & irq_en_reg;

endmodule

// File: tb/tb_pio_count_sequencer.sv
// Directed bench for pio_count_sequencer: a cycle-scheduled reference model is compared
// every clock, plus hand-computed out_port/readdata/irq expectations per scenario.
module tb_pio_count_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pio_count_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: ticks are scheduled as absolute clock numbers
  // (next tick = reload edge + PRESCALE + 1).
  logic [7:0]  m_count = 8'd0;
  logic [3:0]  m_ctrl = 4'd0;
  logic [15:0] m_prescale = 16'd0;
  logic [7:0]  m_limit = 8'hFF;
  logic        m_done = 1'b0;
  longint      cyc = 0;
  longint      m_tick_at = -1;

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_count};
      2'd1:    return {28'd0, m_ctrl};
      2'd2:    return {16'd0, m_prescale};
      default: return {23'd0, m_done, m_limit};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic       wr, fire, at_end, set_done;
    logic [7:0] n_count;
    logic [3:0] n_ctrl;
    logic       n_done;
    if (!reset_n) begin
      m_count = 8'd0; m_ctrl = 4'd0; m_prescale = 16'd0;
      m_limit = 8'hFF; m_done = 1'b0; m_tick_at = -1;
    end else begin
      cyc++;
      wr       = chipselect && !write_n;
      fire     = m_ctrl[0] && (cyc == m_tick_at);
      n_count  = m_count;
      n_ctrl   = m_ctrl;
      n_done   = m_done;
      set_done = 1'b0;
      if (fire) begin
        m_tick_at = cyc + longint'(m_prescale) + 1;
        at_end = m_ctrl[1] ? (m_count == 8'd0) : (m_count == m_limit);
        if (!(wr && address == 2'd0)) begin
          if (at_end) begin
            set_done = 1'b1;
            if (m_ctrl[2]) n_ctrl[0] = 1'b0;
            else n_count = m_ctrl[1] ? m_limit : 8'd0;
          end else begin
            n_count = m_ctrl[1] ? 8'(m_count - 8'd1) : 8'(m_count + 8'd1);
          end
        end
      end
      if (wr) begin
        case (address)
          2'd0: n_count = writedata[7:0];
          2'd1: begin
            if (writedata[0] && !m_ctrl[0]) m_tick_at = cyc + longint'(m_prescale) + 1;
            n_ctrl = writedata[3:0];
          end
          2'd2: m_prescale = writedata[15:0];
          default: begin
            m_limit = writedata[7:0];
            if (writedata[8]) n_done = 1'b0;
          end
        endcase
      end
      m_count = n_count;
      m_ctrl  = n_ctrl;
      m_done  = n_done | set_done;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("model out_port", {24'd0, out_port}, {24'd0, m_count});
      chk("model irq", {31'd0, irq}, {31'd0, m_done & m_ctrl[3]});
      chk("model readdata", readdata, model_rd(address));
    end
  end

  // Called at a negedge; the write lands on the following rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    $display("write addr=%0d data=0x%0h t=%0t", a, d, $time);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic do_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'd0, 32'd0, 32'd0, 32'hFF};
    $display("reset asserted t=%0t", $time);
    reset_n = 1'b0;
    #1;
    chk("reset out_port", {24'd0, out_port}, 32'd0);
    chk("reset irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("reset readdata", 2'(i), exp_rd[i]);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Up count, PRESCALE=3, limit=5: one step every 4 clocks, done at 5->0.
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd5);
    wr(2'd1, 32'h1);
    chk("up start", {24'd0, out_port}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(4);
      chk("up presc3", {24'd0, out_port}, 32'(i));
    end
    rd_chk("up done before wrap", 2'd3, 32'h005);
    step(4);
    chk("up wrap", {24'd0, out_port}, 32'd0);
    rd_chk("up done after wrap", 2'd3, 32'h105);

    // Down count from 2 with limit 9, one step per clock.
    do_reset();
    wr(2'd3, 32'd9);
    wr(2'd0, 32'd2);
    wr(2'd1, 32'h3);
    chk("down 2", {24'd0, out_port}, 32'd2);
    step(1); chk("down 1", {24'd0, out_port}, 32'd1);
    step(1); chk("down 0", {24'd0, out_port}, 32'd0);
    rd_chk("down no done yet", 2'd3, 32'h009);
    step(1); chk("down reload 9", {24'd0, out_port}, 32'd9);
    rd_chk("down done", 2'd3, 32'h109);
    step(1); chk("down 8", {24'd0, out_port}, 32'd8);

    // Oneshot with irq: stops at limit 3, run clears, irq until done cleared.
    do_reset();
    wr(2'd3, 32'd3);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'hD);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("oneshot count", {24'd0, out_port}, 32'(i));
    end
    chk("oneshot irq before terminal", {31'd0, irq}, 32'd0);
    step(1);
    chk("oneshot hold", {24'd0, out_port}, 32'd3);
    chk("oneshot irq", {31'd0, irq}, 32'd1);
    rd_chk("oneshot run cleared", 2'd1, 32'hC);
    step(3);
    chk("oneshot still held", {24'd0, out_port}, 32'd3);
    wr(2'd3, 32'h103);
    chk("oneshot irq cleared", {31'd0, irq}, 32'd0);
    rd_chk("oneshot done cleared", 2'd3, 32'h003);

    // COUNT write on a tick wins; then ignored writes.
    do_reset();
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h55);
    chk("count write wins", {24'd0, out_port}, 32'h55);
    step(1); chk("count after write", {24'd0, out_port}, 32'h56);
    wr(2'd1, 32'h0);
    chk("stop last tick", {24'd0, out_port}, 32'h57);
    address = 2'd0; writedata = 32'hAA; chipselect = 1'b0; write_n = 1'b0;
    step(1);
    chk("cs=0 ignored", {24'd0, out_port}, 32'h57);
    chipselect = 1'b1; write_n = 1'b1;
    step(1);
    chipselect = 1'b0;
    chk("write_n=1 ignored", {24'd0, out_port}, 32'h57);
    step(2);
    chk("run=0 holds", {24'd0, out_port}, 32'h57);

    // PRESCALE rewrite mid-period only affects the next reload.
    do_reset();
    wr(2'd2, 32'd3);
    wr(2'd1, 32'h1);
    step(1);
    wr(2'd2, 32'd1);
    chk("presc old period a", {24'd0, out_port}, 32'd0);
    step(1); chk("presc old period b", {24'd0, out_port}, 32'd0);
    step(1); chk("presc first tick", {24'd0, out_port}, 32'd1);
    step(1); chk("presc new period a", {24'd0, out_port}, 32'd1);
    step(1); chk("presc new period b", {24'd0, out_port}, 32'd2);

    // Done-set coinciding with done-clear: set wins.
    do_reset();
    wr(2'd3, 32'd0);
    wr(2'd1, 32'h1);
    step(2);
    wr(2'd3, 32'h100);
    rd_chk("set beats clear", 2'd3, 32'h100);
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h100);
    rd_chk("clear when idle", 2'd3, 32'h000);

    // Reset mid-count at 7, then no ticks until run rewritten.
    do_reset();
    wr(2'd1, 32'h1);
    step(7);
    chk("pre-reset count", {24'd0, out_port}, 32'd7);
    do_reset();
    step(5);
    chk("no ticks after reset", {24'd0, out_port}, 32'd0);

    // Up mode starting above limit wraps 0xFF->0x00 without done.
    do_reset();
    wr(2'd3, 32'h10);
    wr(2'd0, 32'hFE);
    wr(2'd1, 32'h1);
    address = 2'd3;
    for (int i = 0; i <= 19; i++) begin
      if (i > 0) step(1);
      #1;
      chk("wrap count", {24'd0, out_port}, (i == 19) ? 32'd0 : 32'((8'hFE + i) & 8'hFF));
      chk("wrap done", {31'd0, readdata[8]}, (i == 19) ? 32'd1 : 32'd0);
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
